// File: rtl/cipher_arbiter_if.sv
// Bundles the two channel offers, the stream_cipher core hookup and the
// result/status stream of the cipher arbiter.
interface cipher_arbiter_if;
    logic [7:0] ch0_key;
    logic       ch0_valid;
    logic [7:0] ch0_data;
    logic       ch0_last;
    logic       ch0_ready;

    logic [7:0] ch1_key;
    logic       ch1_valid;
    logic [7:0] ch1_data;
    logic       ch1_last;
    logic       ch1_ready;

    logic [7:0] core_key;
    logic       core_rst_n;
    logic [7:0] core_din;
    logic       core_din_valid;
    logic [7:0] core_dout;
    logic       core_dout_valid;

    logic       out_valid;
    logic [7:0] out_data;
    logic       out_chan;
    logic       out_last;

    logic       busy;
    logic       err_proto;
    logic       err_len;

    // the arbiter side
    modport slave (
        input  ch0_key, ch0_valid, ch0_data, ch0_last,
        input  ch1_key, ch1_valid, ch1_data, ch1_last,
        input  core_dout, core_dout_valid,
        output ch0_ready, ch1_ready,
        output core_key, core_rst_n, core_din, core_din_valid,
        output out_valid, out_data, out_chan, out_last,
        output busy, err_proto, err_len
    );

    // the environment side (channels, core, result sink)
    modport master (
        output ch0_key, ch0_valid, ch0_data, ch0_last,
        output ch1_key, ch1_valid, ch1_data, ch1_last,
        output core_dout, core_dout_valid,
        input  ch0_ready, ch1_ready,
        input  core_key, core_rst_n, core_din, core_din_valid,
        input  out_valid, out_data, out_chan, out_last,
        input  busy, err_proto, err_len
    );
endinterface

// File: rtl/cipher_arbiter.sv
// Two-channel round-robin arbiter in front of a stream_cipher core.
// Each session rekeys the core, streams one packet (or MAX_LEN chars of it)
// and drains the 2-deep result tracker before the next arbitration.
//
// state  | meaning
// IDLE   | no session; arbitrate between requesting channels
// REKEY  | one cycle: core held in reset, core_key loaded from grant
// STREAM | granted channel ready; characters flow into the core
// DRAIN  | wait for the tracker to empty before going idle
module cipher_arbiter #(
    parameter int MAX_LEN = 256
) (
    input logic           clk,
    input logic           rst_n,
    cipher_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REKEY, STREAM, DRAIN} state_t;

    state_t     state, state_nxt;
    logic       grant, grant_nxt;
    logic       last_grant, last_grant_nxt;
    logic [7:0] char_cnt;

    logic       trk0_v, trk0_chan, trk0_last;
    logic       trk1_v, trk1_chan, trk1_last;

    logic       sel_valid, sel_last;
    logic [7:0] sel_data;
    logic       accept, cnt_term, end_sess;

    assign sel_valid = grant ? bus.ch1_valid : bus.ch0_valid;
    assign sel_data  = grant ? bus.ch1_data  : bus.ch0_data;
    assign sel_last  = grant ? bus.ch1_last  : bus.ch0_last;
    assign accept    = (state == STREAM) && sel_valid;
    assign cnt_term  = (char_cnt == 8'(MAX_LEN - 1));
    assign end_sess  = accept && (sel_last || cnt_term);

    assign bus.ch0_ready = (state == STREAM) && !grant;
    assign bus.ch1_ready = (state == STREAM) && grant;

    // next state, grant choice and round-robin history
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (bus.ch0_valid || bus.ch1_valid) begin
                    state_nxt = REKEY;
                    if (bus.ch0_valid && bus.ch1_valid) grant_nxt = ~last_grant;
                    else                                grant_nxt = bus.ch1_valid;
                    last_grant_nxt = grant_nxt;
                end
            end
            REKEY:  state_nxt = STREAM;
            STREAM: if (end_sess) state_nxt = DRAIN;
            // once stage 0 is empty, stage 1 empties on the same edge we leave
            DRAIN:  if (!trk0_v) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM and arbitration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // core control: key sampled at grant, reset pulse during REKEY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.core_key       <= 8'h00;
            bus.core_rst_n     <= 1'b0;
            bus.core_din       <= 8'h00;
            bus.core_din_valid <= 1'b0;
            char_cnt           <= 8'h00;
        end else begin
            bus.core_rst_n     <= (state_nxt != REKEY);
            if (state == IDLE && state_nxt == REKEY)
                bus.core_key <= grant_nxt ? bus.ch1_key : bus.ch0_key;
            bus.core_din_valid <= accept;
            if (accept) bus.core_din <= sel_data;
            if (state == REKEY)  char_cnt <= 8'h00;
            else if (accept)     char_cnt <= char_cnt + 8'h01;
        end
    end

    // tracker pipeline and registered result stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk0_v        <= 1'b0;
            trk0_chan     <= 1'b0;
            trk0_last     <= 1'b0;
            trk1_v        <= 1'b0;
            trk1_chan     <= 1'b0;
            trk1_last     <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 8'h00;
            bus.out_chan  <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            trk0_v        <= accept;
            trk0_chan     <= grant;
            trk0_last     <= end_sess;
            trk1_v        <= trk0_v;
            trk1_chan     <= trk0_chan;
            trk1_last     <= trk0_last;
            bus.out_valid <= trk1_v;
            bus.out_last  <= trk1_v && trk1_last;
            if (trk1_v) begin
                bus.out_data <= bus.core_dout;
                bus.out_chan <= trk1_chan;
            end
        end
    end

    // status flags; errors are sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy      <= 1'b0;
            bus.err_proto <= 1'b0;
            bus.err_len   <= 1'b0;
        end else begin
            bus.busy <= (state_nxt != IDLE);
            if (trk1_v && !bus.core_dout_valid)   bus.err_proto <= 1'b1;
            if (accept && cnt_term && !sel_last)  bus.err_len   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cipher_arbiter.sv
// Directed bench for cipher_arbiter with a behavioural stream_cipher core
// (ctxt = sbox(ptxt ^ (key + offset))) and a session-level output model.
module tb_cipher_arbiter;
    localparam int MAXL = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cipher_arbiter_if bif ();
    cipher_arbiter #(.MAX_LEN(MAXL)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // AES S-box from GF(2^8) inverse plus affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // stream_cipher core model; supp_req != supp_done drops one dout_valid
    logic [7:0] core_off;
    int supp_req = 0;
    int supp_done = 0;
    always @(posedge clk or negedge bif.core_rst_n) begin
        if (!bif.core_rst_n) begin
            core_off            <= 8'h00;
            bif.core_dout_valid <= 1'b0;
            bif.core_dout       <= 8'h00;
        end else begin
            bif.core_dout_valid <= bif.core_din_valid && (supp_req == supp_done);
            if (bif.core_din_valid) begin
                bif.core_dout <= sbox(bif.core_din ^ (bif.core_key + core_off));
                core_off      <= core_off + 8'h01;
                if (supp_req != supp_done) supp_done <= supp_done + 1;
            end
        end
    end

    // session-level reference model fed by observed handshakes
    typedef struct packed {logic [7:0] d; logic c; logic l;} out_t;
    out_t exp_q[$];
    out_t obs_q[$];
    logic [2:0] hist = 3'b000;
    logic exp_err_len = 1'b0;
    logic exp_err_proto = 1'b0;
    bit in_sess = 1'b0;
    logic [7:0] s_key, s_off;
    int s_cnt;
    logic acc0, acc1, ac_chan, ac_last;
    logic [7:0] ac_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist          <= 3'b000;
            exp_err_len   = 1'b0;
            exp_err_proto = 1'b0;
            in_sess       = 1'b0;
            exp_q.delete();
        end else begin
            acc0 = bif.ch0_valid && bif.ch0_ready;
            acc1 = bif.ch1_valid && bif.ch1_ready;
            if (hist[1] && !bif.core_dout_valid) exp_err_proto = 1'b1;
            if (acc0 || acc1) begin
                ac_chan = acc1;
                ac_data = acc1 ? bif.ch1_data : bif.ch0_data;
                ac_last = acc1 ? bif.ch1_last : bif.ch0_last;
                if (!in_sess) begin
                    in_sess = 1'b1;
                    s_key   = acc1 ? bif.ch1_key : bif.ch0_key;
                    s_off   = 8'h00;
                    s_cnt   = 0;
                end
                if (s_cnt == MAXL - 1 && !ac_last) exp_err_len = 1'b1;
                exp_q.push_back('{d: sbox(ac_data ^ (s_key + s_off)), c: ac_chan,
                                  l: ac_last || (s_cnt == MAXL - 1)});
                if (ac_last || s_cnt == MAXL - 1) in_sess = 1'b0;
                s_off = s_off + 8'h01;
                s_cnt++;
            end
            hist <= {hist[1:0], acc0 | acc1};
        end
    end

    // per-cycle comparison against the model
    out_t e;
    logic prev_crst = 1'b0;
    int rst_pulses = 0;
    always @(negedge clk) begin
        chk("out_valid", 32'(bif.out_valid), 32'(hist[2]));
        chk("core_din_valid", 32'(bif.core_din_valid), 32'(hist[0]));
        chk("err_len", 32'(bif.err_len), 32'(exp_err_len));
        chk("err_proto", 32'(bif.err_proto), 32'(exp_err_proto));
        chk("ready_excl", 32'(bif.ch0_ready & bif.ch1_ready), 0);
        if (!rst_n) chk("core_rst_n_in_reset", 32'(bif.core_rst_n), 0);
        if (bif.out_valid === 1'b1) begin
            obs_q.push_back('{d: bif.out_data, c: bif.out_chan, l: bif.out_last});
            chk("out_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", 32'(bif.out_data), 32'(e.d));
                chk("out_chan", 32'(bif.out_chan), 32'(e.c));
                chk("out_last", 32'(bif.out_last), 32'(e.l));
            end
        end
        if (rst_n && prev_crst && !bif.core_rst_n) rst_pulses++;
        prev_crst = bif.core_rst_n;
    end

    logic [7:0] pkt [2][8];

    function automatic logic ready_of(input int c);
        return (c == 1) ? bif.ch1_ready : bif.ch0_ready;
    endfunction

    task automatic drive(input int c, input logic v, input logic [7:0] d, input logic l,
                         input logic [7:0] k);
        if (c == 1) begin
            bif.ch1_valid = v; bif.ch1_data = d; bif.ch1_last = l; bif.ch1_key = k;
        end else begin
            bif.ch0_valid = v; bif.ch0_data = d; bif.ch0_last = l; bif.ch0_key = k;
        end
    endtask

    task automatic send(input int c, input logic [7:0] key, input int n, input int gap_at,
                        input bit with_last);
        int t;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(c, 1'b1, pkt[c][i], with_last && (i == n - 1), key);
            t = 0;
            while (!ready_of(c) && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("accept_in_time", 32'(t < 100), 1);
            if (t >= 100) begin
                drive(c, 1'b0, 8'h00, 1'b0, key);
                return;
            end
            @(posedge clk);
            if (i == gap_at) begin
                @(negedge clk);
                drive(c, 1'b0, pkt[c][i], 1'b0, key);
                repeat (3) @(negedge clk);
                chk("gap_busy", 32'(bif.busy), 1);
                chk("gap_ready", 32'(ready_of(c)), 1);
            end
        end
        @(negedge clk);
        drive(c, 1'b0, 8'h00, 1'b0, key);
    endtask

    task automatic wait_done();
        int t = 0;
        while ((bif.busy || exp_q.size() != 0 || bif.out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_in_time", 32'(t < 300), 1);
        @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ch0_ready"}, 32'(bif.ch0_ready), 0);
        chk({tag, "_ch1_ready"}, 32'(bif.ch1_ready), 0);
        chk({tag, "_core_rst_n"}, 32'(bif.core_rst_n), 0);
        chk({tag, "_core_din_valid"}, 32'(bif.core_din_valid), 0);
        chk({tag, "_out_valid"}, 32'(bif.out_valid), 0);
        chk({tag, "_out_last"}, 32'(bif.out_last), 0);
        chk({tag, "_out_chan"}, 32'(bif.out_chan), 0);
        chk({tag, "_busy"}, 32'(bif.busy), 0);
        chk({tag, "_err_proto"}, 32'(bif.err_proto), 0);
        chk({tag, "_err_len"}, 32'(bif.err_len), 0);
        chk({tag, "_core_key"}, 32'(bif.core_key), 0);
        chk({tag, "_core_din"}, 32'(bif.core_din), 0);
        chk({tag, "_out_data"}, 32'(bif.out_data), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_obs(input string name, input int idx, input logic [7:0] d,
                           input logic c, input logic l);
        chk({name, "_present"}, 32'(obs_q.size() > idx), 1);
        if (obs_q.size() > idx) begin
            chk({name, "_data"}, 32'(obs_q[idx].d), 32'(d));
            chk({name, "_chan"}, 32'(obs_q[idx].c), 32'(c));
            chk({name, "_last"}, 32'(obs_q[idx].l), 32'(l));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 8'h00, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00, 1'b0, 8'h00);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_checks("rst");
        #1 rst_n = 1'b1;
        @(negedge clk);

        // single char, ch0 key 0x41
        obs_q.delete();
        pkt[0][0] = 8'h00;
        send(0, 8'h41, 1, -1, 1'b1);
        wait_done();
        chk("s1_count", 32'(obs_q.size()), 1);
        chk_obs("s1_o0", 0, 8'h83, 1'b0, 1'b1);

        // simultaneous request after reset: ch0 first, then ch1
        do_reset();
        obs_q.delete();
        rst_pulses = 0;
        pkt[0][0] = 8'h00;
        pkt[1][0] = 8'h00;
        pkt[1][1] = 8'h00;
        fork
            send(0, 8'h41, 1, -1, 1'b1);
            send(1, 8'h00, 2, -1, 1'b1);
        join
        wait_done();
        chk("s2_count", 32'(obs_q.size()), 3);
        chk_obs("s2_o0", 0, 8'h83, 1'b0, 1'b1);
        chk_obs("s2_o1", 1, 8'h63, 1'b1, 1'b0);
        chk_obs("s2_o2", 2, 8'h7c, 1'b1, 1'b1);
        chk("s2_core_rst_pulses", 32'(rst_pulses), 2);

        // round-robin: after ch0 alone, contention goes to ch1
        obs_q.delete();
        pkt[0][0] = 8'h11;
        send(0, 8'h05, 1, -1, 1'b1);
        wait_done();
        pkt[0][0] = 8'h33;
        pkt[1][0] = 8'h55;
        fork
            send(0, 8'h22, 1, -1, 1'b1);
            send(1, 8'h44, 1, -1, 1'b1);
        join
        wait_done();
        chk("s3_count", 32'(obs_q.size()), 3);
        if (obs_q.size() == 3) begin
            chk("s3_chan0", 32'(obs_q[0].c), 0);
            chk("s3_chan1", 32'(obs_q[1].c), 1);
            chk("s3_chan2", 32'(obs_q[2].c), 0);
        end

        // length limit: 5 chars with MAX_LEN=4
        obs_q.delete();
        for (int i = 0; i < 5; i++) pkt[0][i] = 8'h00;
        send(0, 8'h00, 5, -1, 1'b1);
        wait_done();
        chk("s4_count", 32'(obs_q.size()), 5);
        chk_obs("s4_o0", 0, 8'h63, 1'b0, 1'b0);
        chk_obs("s4_o1", 1, 8'h7c, 1'b0, 1'b0);
        chk_obs("s4_o2", 2, 8'h77, 1'b0, 1'b0);
        chk_obs("s4_o3", 3, 8'h7b, 1'b0, 1'b1);
        chk_obs("s4_o4", 4, 8'h63, 1'b0, 1'b1);
        chk("s4_err_len", 32'(bif.err_len), 1);

        // valid drop mid-packet keeps the session
        obs_q.delete();
        pkt[1][0] = 8'h01;
        pkt[1][1] = 8'h02;
        pkt[1][2] = 8'h03;
        send(1, 8'h9a, 3, 0, 1'b1);
        wait_done();
        chk("s5_count", 32'(obs_q.size()), 3);
        if (obs_q.size() == 3) chk("s5_last", 32'({obs_q[0].l, obs_q[1].l, obs_q[2].l}), 1);

        // reset mid-session on ch1
        pkt[1][0] = 8'ha0;
        pkt[1][1] = 8'ha1;
        send(1, 8'h37, 2, -1, 1'b0);
        #1 rst_n = 1'b0;
        #1 reset_checks("midrst");
        @(negedge clk);
        #1 rst_n = 1'b1;
        obs_q.delete();
        pkt[1][0] = 8'h00;
        send(1, 8'h00, 1, -1, 1'b1);
        wait_done();
        chk("s6_count", 32'(obs_q.size()), 1);
        chk_obs("s6_o0", 0, 8'h63, 1'b1, 1'b1);

        // dropped core_dout_valid
        obs_q.delete();
        supp_req++;
        pkt[0][0] = 8'h01;
        pkt[0][1] = 8'h02;
        pkt[0][2] = 8'h03;
        send(0, 8'h10, 3, -1, 1'b1);
        wait_done();
        chk("s7_err_proto", 32'(bif.err_proto), 1);
        chk("s7_out_count", 32'(obs_q.size()), 3);
        repeat (5) @(negedge clk);
        chk("s7_err_proto_sticky", 32'(bif.err_proto), 1);
        do_reset();
        chk("s7_err_proto_cleared", 32'(bif.err_proto), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cipher_arbiter.md
CIPHER_ARBITER -- requirements
Module: cipher_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_LEN, default 256, maximum characters per session; legal range 2..256.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have ports chX_key, input, 8, the session key of channel X (X=0,1); sampled at grant.
REQ-005 The block SHALL have ports chX_valid / chX_data[7:0] / chX_last, inputs, the character offer of channel X; chX_last marks the packet end.
REQ-006 The block SHALL have port chX_ready, output, 1; a character is accepted on an edge where chX_valid and chX_ready are both high.
REQ-007 The block SHALL have ports core_key[7:0] / core_rst_n / core_din[7:0] / core_din_valid, outputs that drive the stream_cipher key/rst_n/ptxt_char/din_valid.
REQ-008 The block SHALL have ports core_dout[7:0] / core_dout_valid, inputs taken from the stream_cipher ctxt_char/dout_valid.
REQ-009 The block SHALL have ports out_valid / out_data[7:0] / out_chan / out_last, outputs carrying the result stream; there is no backpressure.
REQ-010 The block SHALL have ports busy, err_proto and err_len, outputs, 1 each.

Function
REQ-011 The FSM SHALL have the states IDLE, REKEY, STREAM and DRAIN; all outputs SHALL be registered except chX_ready, which is decoded from state and grant.
REQ-012 In IDLE, if any chX_valid is high, the FSM SHALL grant one channel and go to REKEY.
- Both requesting: grant the channel not granted last (round-robin).
- The last-grant register SHALL reset to 1, so ch0 wins the first contention.
REQ-013 In REKEY (exactly 1 cycle), the block SHALL drive core_rst_n low and load core_key from the granted chX_key.
- core_key SHALL hold that value until the next REKEY.
- The FSM SHALL then go to STREAM.
REQ-014 In STREAM, only the granted channel's ready SHALL be high; chX_ready SHALL be 0 in every other state.
REQ-015 An accepted character SHALL appear on core_din with core_din_valid=1 in the next cycle; core_din_valid SHALL be 0 in cycles with no acceptance.
REQ-016 A 2-stage tracker pipeline SHALL carry {valid, chan, last} alongside each accepted character.
- out_valid SHALL rise exactly 2 cycles after acceptance.
- out_data SHALL be the registered core_dout; out_chan and out_last SHALL come from the tracker.
REQ-017 A session character counter (8-bit, cleared in REKEY) SHALL increment per acceptance.
REQ-018 If chX_last is accepted, or the counter reaches MAX_LEN-1 at acceptance, the FSM SHALL go to DRAIN and that character SHALL be tagged out_last=1.
REQ-019 If termination is by count without chX_last, err_len SHALL set (sticky); the remaining characters of that packet SHALL form a new session after re-arbitration, with the keystream offset restarting at 0.
REQ-020 DRAIN SHALL last until the tracker is empty (2 cycles), then the FSM SHALL go to IDLE; the minimum gap between sessions is therefore 4 cycles (DRAIN 2, IDLE 1, REKEY 1).
REQ-021 If core_dout_valid is low when tracker stage 1 is valid, err_proto SHALL set (sticky); out_valid SHALL still be asserted from the tracker.
REQ-022 busy SHALL be high in every state except IDLE.
REQ-023 A chX_valid drop mid-packet SHALL NOT end the session; STREAM SHALL wait indefinitely.

Reset
REQ-024 While rst_n is low, core_rst_n SHALL be low asynchronously.
REQ-025 Reset values:
- FSM = IDLE, grant = 0, last-grant = 1, counter = 0, tracker empty.
- chX_ready, core_din_valid, out_valid, out_last, out_chan, busy, err_proto, err_len = 0.
- core_key, core_din, out_data = 0x00.
REQ-026 A reset mid-session SHALL abandon the session; the next session SHALL start with keystream offset 0.

Verification
REQ-027 ch0 key 0x41 sends one char 0x00 with last=1 -> one output 0x83, out_chan=0, out_last=1, 2 cycles after acceptance.
REQ-028 After reset, both channels request in the same cycle: ch0 key 0x41 data {0x00,last}, ch1 key 0x00 data {0x00, 0x00,last} -> ch0 is served first (0x83), then ch1 (0x63, then 0x7c with last); core_rst_n pulses low once per session.
REQ-029 MAX_LEN=4, ch0 key 0x00 sends 5 chars of 0x00, last on the 5th -> outputs 0x63, 0x7c, 0x77, 0x7b (last); err_len=1; 5th char -> new session, output 0x63 with last.
REQ-030 rst_n is pulsed low after 2 of 4 chars of a ch1 session -> all outputs return to reset values at once; a new ch1 packet key 0x00 data 0x00 -> 0x63.
REQ-031 Core model suppresses one core_dout_valid -> err_proto=1 and stays 1 until reset; out_valid count still equals the number of accepted chars.
